// File: rtl/indication_output_queue.sv
// indication_output_queue: round-robin merge of NUM_CH indication channels into a
// DEPTH-entry FIFO, drained in order through one PipeIn-style enq port.
//
// Handshake: a channel call is taken on a cycle where ind_heard__ENA[i] and
// ind_heard__RDY[i] are both high. The caller holds ENA and its meth/v fields
// steady until that cycle. RDY is a function of the ENA vector.
// On the output side, pipe_enq__ENA is a commit strobe. It is only raised when
// pipe_enq__RDY is high, and every cycle it is high consumes the head message.
module indication_output_queue #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4,
  parameter int METH_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                                    CLK,
  input  logic                                    nRST,
  input  logic [NUM_CH-1:0]                       ind_heard__ENA,
  output logic [NUM_CH-1:0]                       ind_heard__RDY,
  input  logic [NUM_CH*METH_WIDTH-1:0]            ind_heard_meth,
  input  logic [NUM_CH*DATA_WIDTH-1:0]            ind_heard_v,
  output logic                                    pipe_enq__ENA,
  input  logic                                    pipe_enq__RDY,
  output logic [TAG_WIDTH+METH_WIDTH+DATA_WIDTH-1:0] pipe_enq_v,
  output logic [$clog2(DEPTH):0]                  occupancy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MSG_W = TAG_WIDTH + METH_WIDTH + DATA_WIDTH;

  logic [MSG_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [TAG_WIDTH-1:0] rr_last;

  logic                  full;
  logic                  found;
  logic                  hit;
  logic [TAG_WIDTH-1:0]  winner;
  logic [TAG_WIDTH-1:0]  cand;
  logic                  accept;
  logic                  drain;
  logic [METH_WIDTH-1:0] sel_meth;
  logic [DATA_WIDTH-1:0] sel_v;

  // Channel index following c, wrapping at NUM_CH.
  function automatic logic [TAG_WIDTH-1:0] next_ch(input logic [TAG_WIDTH-1:0] c);
    if (c >= TAG_WIDTH'(NUM_CH - 1)) next_ch = '0;
    else                             next_ch = c + 1'b1;
  endfunction

  assign full = (count == (AW+1)'(DEPTH));

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    hit    = 1'b0;
    cand   = next_ch(rr_last);
    for (int k = 0; k < NUM_CH; k++) begin
      hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cand == TAG_WIDTH'(i)) hit = ind_heard__ENA[i];
      end
      if (!found && hit) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_ch(cand);
    end
  end

  // One-hot grant to the winner; reset holds every grant low.
  always_comb begin
    ind_heard__RDY = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ind_heard__RDY[i] = nRST && found && !full && (winner == TAG_WIDTH'(i));
    end
  end

  // Select the winner's method id and payload for the FIFO write.
  always_comb begin
    sel_meth = '0;
    sel_v    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner == TAG_WIDTH'(i)) begin
        sel_meth = ind_heard_meth[i*METH_WIDTH +: METH_WIDTH];
        sel_v    = ind_heard_v[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept        = |(ind_heard__ENA & ind_heard__RDY);
  assign drain         = (count != '0) && pipe_enq__RDY;
  assign pipe_enq__ENA = drain;
  assign pipe_enq_v    = (count != '0) ? mem[rd_ptr] : '0;
  assign occupancy     = count;

  // Message storage; contents are meaningless while count says empty, so no reset.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= {winner + 1'b1, sel_meth, sel_v};
  end

  // Pointers, entry count and round-robin history.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_last <= TAG_WIDTH'(NUM_CH - 1);
    end else begin
      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rr_last <= winner;
      end
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !drain)      count <= count + 1'b1;
      else if (!accept && drain) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_indication_output_queue.sv
// Bench for indication_output_queue: per-channel source queues, a queue-based
// reference FIFO with round-robin winner choice, checks every cycle.
module tb_indication_output_queue;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int MW     = 32;
  localparam int DW     = 32;
  localparam int TW     = 4;
  localparam int MSG_W  = TW + MW + DW;
  localparam int OW     = $clog2(DEPTH) + 1;

  // rdy modes
  localparam int NEVER = 0, ALWAYS = 1, ALTERNATE = 2, RANDOM = 3;

  logic                   CLK;
  logic                   nRST;
  logic [NUM_CH-1:0]      ind_heard__ENA;
  logic [NUM_CH-1:0]      ind_heard__RDY;
  logic [NUM_CH*MW-1:0]   ind_heard_meth;
  logic [NUM_CH*DW-1:0]   ind_heard_v;
  logic                   pipe_enq__ENA;
  logic                   pipe_enq__RDY;
  logic [MSG_W-1:0]       pipe_enq_v;
  logic [OW-1:0]          occupancy;

  indication_output_queue #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .METH_WIDTH(MW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ind_heard__ENA(ind_heard__ENA),
    .ind_heard__RDY(ind_heard__RDY),
    .ind_heard_meth(ind_heard_meth),
    .ind_heard_v(ind_heard_v),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq__RDY(pipe_enq__RDY),
    .pipe_enq_v(pipe_enq_v),
    .occupancy(occupancy)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // pending calls per channel, each {meth, v}
  logic [MW+DW-1:0] src0[$];
  logic [MW+DW-1:0] src1[$];

  // scoreboard: expected FIFO contents in order, plus arbitration history
  logic [MSG_W-1:0] exp_q[$];
  int               model_last;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_msg(input int ch, input logic [MW-1:0] m, input logic [DW-1:0] v);
    if (ch == 0) src0.push_back({m, v});
    else         src1.push_back({m, v});
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model.
  task automatic step(input int mode);
    logic [MW+DW-1:0] call [NUM_CH];
    logic [NUM_CH-1:0] ena;
    logic [NUM_CH-1:0] exp_rdy;
    int                w;
    bit                exp_drain;
    bit                exp_acc;
    @(negedge CLK);
    cyc++;
    call[0] = (src0.size() != 0) ? src0[0] : '0;
    call[1] = (src1.size() != 0) ? src1[0] : '0;
    ena     = {src1.size() != 0, src0.size() != 0};
    ind_heard__ENA = ena;
    for (int i = 0; i < NUM_CH; i++) begin
      ind_heard_meth[i*MW +: MW] = call[i][MW+DW-1:DW];
      ind_heard_v[i*DW +: DW]    = call[i][DW-1:0];
    end
    case (mode)
      NEVER:     pipe_enq__RDY = 1'b0;
      ALWAYS:    pipe_enq__RDY = 1'b1;
      ALTERNATE: pipe_enq__RDY = cyc[0];
      default:   pipe_enq__RDY = 1'($urandom_range(0, 1));
    endcase
    #1;
    // reference: first requester after the last winner, unless the FIFO is full
    w = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (model_last + k) % NUM_CH;
      if (w < 0 && ena[c]) w = c;
    end
    exp_acc   = (w >= 0) && (exp_q.size() < DEPTH);
    exp_rdy   = exp_acc ? NUM_CH'(1 << w) : '0;
    exp_drain = (exp_q.size() != 0) && pipe_enq__RDY;
    check_eq("rdy", 128'(ind_heard__RDY), 128'(exp_rdy));
    check_eq("enq_ena", 128'(pipe_enq__ENA), 128'(exp_drain));
    check_eq("enq_v", 128'(pipe_enq_v), (exp_q.size() != 0) ? 128'(exp_q[0]) : 128'(0));
    check_eq("occupancy", 128'(occupancy), 128'(exp_q.size()));
    if (exp_drain) void'(exp_q.pop_front());
    if (exp_acc) begin
      exp_q.push_back({TW'(w + 1), call[w]});
      model_last = w;
    end
    // sources retire on the handshake they actually see
    if (ena[0] && ind_heard__RDY[0]) void'(src0.pop_front());
    if (ena[1] && ind_heard__RDY[1]) void'(src1.pop_front());
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_last = NUM_CH - 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_occ"}, 128'(occupancy), 128'(0));
    check_eq({tag, "_ena"}, 128'(pipe_enq__ENA), 128'(0));
    check_eq({tag, "_v"}, 128'(pipe_enq_v), 128'(0));
    check_eq({tag, "_rdy"}, 128'(ind_heard__RDY), 128'(0));
  endtask

  initial begin
    int guard;
    nRST           = 1'b0;
    ind_heard__ENA = '0;
    ind_heard_meth = '0;
    ind_heard_v    = '0;
    pipe_enq__RDY  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // single message from ch0
    push_msg(0, 32'd5, 32'hA5);
    step(ALWAYS);
    step(ALWAYS);
    step(ALWAYS);

    // round robin with both channels busy
    for (int i = 0; i < 4; i++) begin
      push_msg(0, 32'(100 + i), $urandom);
      push_msg(1, 32'(200 + i), $urandom);
    end
    repeat (11) step(ALWAYS);

    // fill and overflow from ch1, then drain
    for (int i = 1; i <= 6; i++) push_msg(1, $urandom, 32'(i));
    repeat (6) step(NEVER);
    repeat (10) step(ALWAYS);

    // full with concurrent drain: fill to DEPTH, then ch0 keeps requesting
    for (int i = 0; i < DEPTH; i++) push_msg(1, $urandom, $urandom);
    repeat (DEPTH + 1) step(NEVER);
    for (int i = 0; i < 3; i++) push_msg(0, $urandom, $urandom);
    repeat (10) step(ALWAYS);

    // wrap-around stream with downstream ready every other cycle
    for (int i = 0; i < 3 * DEPTH + 1; i++) push_msg($urandom_range(0, 1), $urandom, 32'(1000 + i));
    repeat (40) step(ALTERNATE);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) push_msg(0, $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) push_msg(1, $urandom, $urandom);
      step(RANDOM);
    end
    guard = 0;
    while ((src0.size() != 0 || src1.size() != 0 || exp_q.size() != 0) && guard < 100) begin
      step(ALWAYS);
      guard++;
    end
    check_eq("drain_timeout", 128'(guard < 100), 128'(1));

    // asynchronous reset mid-stream at occupancy 3
    for (int i = 0; i < 3; i++) push_msg(0, $urandom, $urandom);
    repeat (4) step(NEVER);
    check_eq("pre_reset_occ", 128'(occupancy), 128'(3));
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    src0.delete();
    src1.delete();
    push_msg(0, 32'd7, 32'h11);
    push_msg(1, 32'd8, 32'h22);
    repeat (5) step(ALWAYS);
    check_eq("post_reset_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
